rvfi_mem_responder: RTL and testbench

Parametrised, multi-channel memory responder for the formal and simulation harness around the core. It answers NUM_CH valid/ready request channels (instruction fetch, data, and future extra masters) using externally supplied nondeterministic stall and read-data inputs. It tracks per-channel wait state, enforces a bounded-wait fairness guarantee, and raises sticky flags for protocol violations and accesses into an excluded (memory-mapped) address window. It sits between the core's memory ports and the harness's `rvformal_rand_reg` sources, replacing per-signal ad-hoc assumptions.

---
 rtl/rvfi_mem_responder.sv | 132 +++++++++++++
 tb/tb_rvfi_mem_responder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/rvfi_mem_responder.sv
// Multi-channel memory responder for the formal/simulation harness: answers valid/ready
// channels with nondeterministic stalls and data. Optional bounded-wait fairness: RVFI_MEM_FAIRNESS_EN.
module rvfi_mem_responder #(
    parameter int             NUM_CH    = 2,
    parameter int             AW        = 32,
    parameter int             DW        = 32,
    parameter int             MAX_WAIT  = 3,
    parameter logic [AW-1:0]  EXCL_BASE = AW'(32'hA000_0000),
    parameter logic [AW-1:0]  EXCL_SIZE = AW'(32'h0000_0020),
    localparam int            CW        = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_CH-1:0]    valid_i,
    input  logic [NUM_CH*AW-1:0] addr_i,
    input  logic [NUM_CH-1:0]    rand_stall_i,
    input  logic [NUM_CH*DW-1:0] rand_data_i,
    output logic [NUM_CH-1:0]    ready_o,
    output logic [NUM_CH*DW-1:0] rdata_o,
    output logic [NUM_CH*CW-1:0] wait_cnt_o,
    output logic [NUM_CH-1:0]    stall_max_o,
    output logic [NUM_CH-1:0]    excl_hit_o,
    output logic [NUM_CH-1:0]    proto_err_o
);

    typedef enum logic {IDLE, PEND} state_t;

    // Window bounds carry one extra bit so a window touching the top of memory cannot wrap.
    localparam logic [AW:0]   EXCL_LO = {1'b0, EXCL_BASE};
    localparam logic [AW:0]   EXCL_HI = EXCL_LO + {1'b0, EXCL_SIZE};
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);
    localparam logic [CW-1:0] CNT_ONE = (MAX_WAIT == 0) ? '0 : CW'(1);

    state_t        state_q [NUM_CH];
    state_t        state_d [NUM_CH];
    logic [CW-1:0] cnt_q   [NUM_CH];
    logic [CW-1:0] cnt_d   [NUM_CH];
    logic [AW-1:0] cap_q   [NUM_CH];
    logic [AW-1:0] cap_d   [NUM_CH];
    logic [AW-1:0] addr    [NUM_CH];
    logic [DW-1:0] hold_q  [NUM_CH];
    logic [DW-1:0] data    [NUM_CH];

    logic [NUM_CH-1:0] forced;
    logic [NUM_CH-1:0] ready;
    logic [NUM_CH-1:0] excl_now;
    logic [NUM_CH-1:0] proto_now;
    logic [NUM_CH-1:0] excl_q;
    logic [NUM_CH-1:0] proto_q;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            addr[c] = addr_i[c*AW +: AW];
            data[c] = rand_data_i[c*DW +: DW];
        end
    end

    // Per-channel handshake, next-state and output logic; channels never interact.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            state_d[c]   = state_q[c];
            cnt_d[c]     = cnt_q[c];
            cap_d[c]     = cap_q[c];
            proto_now[c] = 1'b0;
`ifdef RVFI_MEM_FAIRNESS_EN
            forced[c]    = (cnt_q[c] == CNT_MAX);
`else
            forced[c]    = 1'b0;
`endif
            ready[c]     = !reset && valid_i[c] && (!rand_stall_i[c] || forced[c]);
            excl_now[c]  = valid_i[c] && ({1'b0, addr[c]} >= EXCL_LO) && ({1'b0, addr[c]} < EXCL_HI);

            case (state_q[c])
                IDLE: begin
                    if (valid_i[c] && !ready[c]) begin
                        state_d[c] = PEND;
                        cap_d[c]   = addr[c];
                        cnt_d[c]   = CNT_ONE;
                    end else begin
                        cnt_d[c]   = '0;
                    end
                end
                PEND: begin
                    proto_now[c] = !valid_i[c] || (addr[c] != cap_q[c]);
                    if (!valid_i[c] || ready[c]) begin
                        state_d[c] = IDLE;
                        cnt_d[c]   = '0;
                    end else if (cnt_q[c] != CNT_MAX) begin
                        cnt_d[c]   = cnt_q[c] + CW'(1);
                    end
                end
                default: begin
                    state_d[c] = IDLE;
                    cnt_d[c]   = '0;
                end
            endcase

            ready_o[c]            = ready[c];
            rdata_o[c*DW +: DW]   = ready[c] ? data[c] : hold_q[c];
            wait_cnt_o[c*CW +: CW] = cnt_q[c];
            stall_max_o[c]        = (state_q[c] == PEND) && (cnt_q[c] == CNT_MAX);
        end
        excl_hit_o  = excl_q;
        proto_err_o = proto_q;
    end

    // Reset drops any in-flight request silently; sticky flags only accumulate otherwise.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= IDLE;
                cnt_q[c]   <= '0;
                cap_q[c]   <= '0;
                hold_q[c]  <= '0;
            end
            excl_q  <= '0;
            proto_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= state_d[c];
                cnt_q[c]   <= cnt_d[c];
                cap_q[c]   <= cap_d[c];
                if (ready[c]) begin
                    hold_q[c] <= data[c];
                end
            end
            excl_q  <= excl_q | excl_now;
            proto_q <= proto_q | proto_now;
        end
    end

endmodule

// File: tb/tb_rvfi_mem_responder.sv
// Directed plus randomized bench for rvfi_mem_responder against a request-level reference model.
// Builds with or without RVFI_MEM_FAIRNESS_EN; the model follows the same macro.
module tb_rvfi_mem_responder;

    localparam int NUM_CH   = 2;
    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int MAX_WAIT = 3;
    localparam int CW       = 2;
    localparam logic [AW:0] WIN_LO = 33'h0_A000_0000;
    localparam logic [AW:0] WIN_HI = 33'h0_A000_0020;
`ifdef RVFI_MEM_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic                 clock = 1'b0;
    logic                 reset;
    logic [NUM_CH-1:0]    valid_i;
    logic [NUM_CH*AW-1:0] addr_i;
    logic [NUM_CH-1:0]    rand_stall_i;
    logic [NUM_CH*DW-1:0] rand_data_i;
    logic [NUM_CH-1:0]    ready_o;
    logic [NUM_CH*DW-1:0] rdata_o;
    logic [NUM_CH*CW-1:0] wait_cnt_o;
    logic [NUM_CH-1:0]    stall_max_o;
    logic [NUM_CH-1:0]    excl_hit_o;
    logic [NUM_CH-1:0]    proto_err_o;

    rvfi_mem_responder #(.NUM_CH(NUM_CH), .AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .clock(clock), .reset(reset), .valid_i(valid_i), .addr_i(addr_i),
        .rand_stall_i(rand_stall_i), .rand_data_i(rand_data_i), .ready_o(ready_o),
        .rdata_o(rdata_o), .wait_cnt_o(wait_cnt_o), .stall_max_o(stall_max_o),
        .excl_hit_o(excl_hit_o), .proto_err_o(proto_err_o)
    );

    always #5 clock = ~clock;

    // Model: a channel either has an outstanding request or not; "run" is how many
    // cycles the current request has been refused so far, capped at MAX_WAIT.
    bit            m_pend [NUM_CH];
    int            m_run  [NUM_CH];
    logic [AW-1:0] m_cap  [NUM_CH];
    logic [DW-1:0] m_hold [NUM_CH];
    bit            m_excl [NUM_CH];
    bit            m_perr [NUM_CH];

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    function automatic logic [AW-1:0] ch_addr(input int c);
        return addr_i[c*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] ch_data(input int c);
        return rand_data_i[c*DW +: DW];
    endfunction

    function automatic bit in_window(input logic [AW-1:0] a);
        return ({1'b0, a} >= WIN_LO) && ({1'b0, a} < WIN_HI);
    endfunction

    function automatic bit m_ready(input int c);
        return !reset && valid_i[c] && (!rand_stall_i[c] || (FAIR && m_run[c] == MAX_WAIT));
    endfunction

    task automatic compare(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_output();
        logic [NUM_CH-1:0]    e_ready, e_smax, e_excl, e_perr;
        logic [NUM_CH*DW-1:0] e_rdata;
        logic [NUM_CH*CW-1:0] e_cnt;
        for (int c = 0; c < NUM_CH; c++) begin
            e_ready[c]          = m_ready(c);
            e_rdata[c*DW +: DW] = e_ready[c] ? ch_data(c) : m_hold[c];
            e_cnt[c*CW +: CW]   = CW'(m_run[c]);
            e_smax[c]           = m_pend[c] && (m_run[c] == MAX_WAIT);
            e_excl[c]           = m_excl[c];
            e_perr[c]           = m_perr[c];
        end
        compare("ready",     64'(ready_o),     64'(e_ready));
        compare("rdata",     64'(rdata_o),     64'(e_rdata));
        compare("wait_cnt",  64'(wait_cnt_o),  64'(e_cnt));
        compare("stall_max", 64'(stall_max_o), 64'(e_smax));
        compare("excl_hit",  64'(excl_hit_o),  64'(e_excl));
        compare("proto_err", 64'(proto_err_o), 64'(e_perr));
    endtask

    task automatic update_model();
        for (int c = 0; c < NUM_CH; c++) begin
            if (reset) begin
                m_pend[c] = 0; m_run[c] = 0; m_cap[c] = '0;
                m_hold[c] = '0; m_excl[c] = 0; m_perr[c] = 0;
            end else begin
                bit r;
                r = m_ready(c);
                if (valid_i[c] && in_window(ch_addr(c))) m_excl[c] = 1;
                if (m_pend[c] && (!valid_i[c] || ch_addr(c) != m_cap[c])) m_perr[c] = 1;
                if (r) begin
                    m_hold[c] = ch_data(c);
                    m_pend[c] = 0;
                    m_run[c]  = 0;
                end else if (valid_i[c]) begin
                    if (!m_pend[c]) begin
                        m_pend[c] = 1;
                        m_cap[c]  = ch_addr(c);
                    end
                    if (m_run[c] < MAX_WAIT) m_run[c]++;
                end else begin
                    m_pend[c] = 0;
                    m_run[c]  = 0;
                end
            end
        end
    endtask

    // Inputs change at the falling edge; outputs are checked 1 time unit later.
    task automatic apply_stimulus();
        rand_data_i = {$urandom, $urandom};
        #1;
        check_output();
        @(posedge clock);
        update_model();
        @(negedge clock);
    endtask

    task automatic drive(input int c, input logic v, input logic [AW-1:0] a, input logic s);
        valid_i[c]          = v;
        addr_i[c*AW +: AW]  = a;
        rand_stall_i[c]     = s;
    endtask

    logic [AW-1:0] excl_list [4] = '{32'hA000_001C, 32'hA000_0020, 32'h9FFF_FFFF, 32'hA000_0000};

    initial begin
        for (int c = 0; c < NUM_CH; c++) begin
            m_pend[c] = 0; m_run[c] = 0; m_cap[c] = '0;
            m_hold[c] = '0; m_excl[c] = 0; m_perr[c] = 0;
        end
        reset = 1'b1;
        valid_i = '0; addr_i = '0; rand_stall_i = '0; rand_data_i = '0;
        @(negedge clock);

        // Requests during reset must never be accepted.
        drive(0, 1, 32'h100, 0);
        drive(1, 1, 32'h200, 1);
        apply_stimulus();
        apply_stimulus();
        reset = 1'b0;

        // Unstalled request is accepted immediately.
        drive(1, 0, 32'h0, 0);
        apply_stimulus();

        // Held stall: bounded with fairness, saturating count without.
        drive(0, 1, 32'h100, 1);
        repeat (10) apply_stimulus();
        drive(0, 0, 32'h0, 0);
        apply_stimulus();

        // Address changes while pending, then the request is withdrawn.
        drive(1, 1, 32'h200, 1);
        apply_stimulus();
        drive(1, 1, 32'h204, 1);
        apply_stimulus();
        drive(1, 0, 32'h0, 0);
        apply_stimulus();
        reset = 1'b1;
        apply_stimulus();
        reset = 1'b0;
        drive(1, 1, 32'h300, 1);
        apply_stimulus();
        drive(1, 0, 32'h300, 0);
        apply_stimulus();
        apply_stimulus();

        // Window boundaries.
        foreach (excl_list[i]) begin
            drive(0, 1, excl_list[i], 0);
            apply_stimulus();
            drive(0, 0, 32'h0, 0);
            apply_stimulus();
        end

        // Reset while a request is two cycles into its stall.
        drive(0, 1, 32'h400, 1);
        apply_stimulus();
        apply_stimulus();
        reset = 1'b1;
        apply_stimulus();
        apply_stimulus();
        reset = 1'b0;
        drive(0, 0, 32'h0, 0);
        apply_stimulus();

        // Random traffic: addresses mostly held, occasional changes, drops and resets.
        repeat (400) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 5) == 0) valid_i[c] = ~valid_i[c];
                if ($urandom_range(0, 9) == 0) begin
                    case ($urandom_range(0, 4))
                        0: addr_i[c*AW +: AW] = 32'h100;
                        1: addr_i[c*AW +: AW] = 32'h104;
                        2: addr_i[c*AW +: AW] = 32'hA000_0000 + 32'($urandom_range(0, 63));
                        3: addr_i[c*AW +: AW] = 32'h9FFF_FFFC;
                        default: addr_i[c*AW +: AW] = 32'hFFFF_FFFC;
                    endcase
                end
                rand_stall_i[c] = ($urandom_range(0, 9) < 7);
            end
            reset = ($urandom_range(0, 99) == 0);
            apply_stimulus();
        end
        reset = 1'b0;
        apply_stimulus();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
